// File: rtl/cordic_sched_if.sv
// Requester and result channels of cordic_sched.
// Handshake rule for every channel: a transfer happens on a rising clock edge where valid and ready are both high.
interface cordic_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_x;
  logic [31:0] req0_y;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_x;
  logic [31:0] req1_y;
  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic        res_err;
  logic [31:0] res_mod;
  logic [31:0] res_angle;

  modport slave (
    input  req0_valid, req0_x, req0_y,
    output req0_ready,
    input  req1_valid, req1_x, req1_y,
    output req1_ready,
    output res_valid, res_id, res_err, res_mod, res_angle,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_x, req0_y,
    input  req0_ready,
    output req1_valid, req1_x, req1_y,
    input  req1_ready,
    input  res_valid, res_id, res_err, res_mod, res_angle,
    output res_ready
  );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin sequencer sharing one rec2pol CORDIC between two requesters:
// accepts one job at a time, runs start + NITER enable cycles, returns the tagged result.
module cordic_sched #(
  parameter int unsigned NITER = 32,            // legal 1..63, counter is 6 bits
  parameter logic [31:0] XMAX  = 32'h7FFE_FFFF
) (
  input  logic           clock,
  input  logic           reset,
  cordic_sched_if.slave  bus,
  output logic           busy,
  output logic           cordic_start,
  output logic           cordic_enable,
  output logic [31:0]    cordic_x,
  output logic [31:0]    cordic_y,
  input  logic [31:0]    cordic_mod,
  input  logic [31:0]    cordic_angle,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] CNT_LOAD = 6'(NITER - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic [31:0] mod_q, mod_d;
  logic [31:0] angle_q, angle_d;
  logic        start_q, start_d;
  logic        enable_q, enable_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic        grant;
  logic        ready0;
  logic        ready1;
  logic        accept;
  logic [31:0] x_sel;
  logic [31:0] y_sel;
  logic        x_bad;

  // Arbitration: on a tie the requester that was not served last wins.
  always_comb begin
    grant  = 1'b0;
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
    // Gated by reset so both readies read 0 while reset is held.
    ready0 = reset && (state_q == S_IDLE) && bus.req0_valid && !grant;
    ready1 = reset && (state_q == S_IDLE) && bus.req1_valid &&  grant;
  end

  assign accept = ready0 || ready1;
  assign x_sel  = grant ? bus.req1_x : bus.req0_x;
  assign y_sel  = grant ? bus.req1_y : bus.req0_y;
  assign x_bad  = ($signed(x_sel) < 0) || (x_sel > XMAX);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    id_d         = id_q;
    err_d        = err_q;
    mod_d        = mod_q;
    angle_d      = angle_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d          = x_sel;
          y_d          = y_sel;
          id_d         = grant;
          last_grant_d = grant;
          if (x_bad) begin
            // Rejected jobs never touch the CORDIC.
            err_d   = 1'b1;
            mod_d   = '0;
            angle_d = '0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        cnt_d   = CNT_LOAD;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (cnt_q == 6'd0) begin
          mod_d   = cordic_mod;
          angle_d = cordic_angle;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Control outputs are registered copies of the next-state decode.
    start_d  = (state_d == S_START);
    enable_d = (state_d == S_START) || (state_d == S_ITER);
    valid_d  = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      mod_q        <= '0;
      angle_q      <= '0;
      start_q      <= 1'b0;
      enable_q     <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      id_q         <= id_d;
      err_q        <= err_d;
      mod_q        <= mod_d;
      angle_q      <= angle_d;
      start_q      <= start_d;
      enable_q     <= enable_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = valid_q;
  assign bus.res_id     = id_q;
  assign bus.res_err    = err_q;
  assign bus.res_mod    = mod_q;
  assign bus.res_angle  = angle_q;
  assign busy           = busy_q;
  assign cordic_start   = start_q;
  assign cordic_enable  = enable_q;
  assign cordic_x       = x_q;
  assign cordic_y       = y_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: per-requester job queues drive the handshakes, a real-arithmetic
// rec2pol model sits behind the CORDIC port, and a monitor checks results against exp_q.
module tb_cordic_sched;
  localparam int          NITER = 32;
  localparam logic [31:0] XMAX  = 32'h7FFE_FFFF;
  localparam int          W     = 66;
  localparam real         PI    = 3.14159265358979323846;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy, cordic_start, cordic_enable;
  logic [31:0] cordic_x, cordic_y, cordic_mod, cordic_angle;
  logic [1:0]  dbg_state;

  cordic_sched_if bus();

  cordic_sched #(.NITER(NITER), .XMAX(XMAX)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .busy(busy), .cordic_start(cordic_start), .cordic_enable(cordic_enable),
    .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_mod(cordic_mod), .cordic_angle(cordic_angle),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // ---------------- shared bench state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] job_q0[$];
  logic [63:0] job_q1[$];
  logic [W-1:0] exp_q[$];
  logic        grant_log[$];
  bit          gaps = 1'b0;
  bit          cons_hold = 1'b0;
  bit          cons_rand = 1'b0;
  int          en_cnt = 0;
  bit          in_job = 1'b0;
  logic        last_id, last_err;
  logic [31:0] last_mod, last_ang;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rec2pol ----------------
  function automatic logic [31:0] ref_mod(input logic [31:0] x, input logic [31:0] y);
    real xr, yr, m;
    longint q;
    xr = $itor($signed(x)) / 65536.0;
    yr = $itor($signed(y)) / 65536.0;
    m  = $sqrt(xr * xr + yr * yr) * 65536.0;
    q  = longint'(m);
    return q[31:0];
  endfunction

  function automatic logic [31:0] ref_ang(input logic [31:0] x, input logic [31:0] y);
    real xr, yr, a;
    longint q;
    xr = $itor($signed(x)) / 65536.0;
    yr = $itor($signed(y)) / 65536.0;
    a  = $atan2(yr, xr) * 180.0 / PI * 16777216.0;
    q  = longint'(a);
    return q[31:0];
  endfunction

  // x must lie in [0, 32767.0) to be accepted for conversion
  function automatic bit ref_bad(input logic [31:0] x);
    real xr;
    xr = $itor($signed(x)) / 65536.0;
    return (xr < 0.0) || (xr >= 32767.0);
  endfunction

  // External CORDIC: final answer only on the cycle of the last iteration, noise otherwise.
  int          it_cnt;
  logic [31:0] mdl_mod, mdl_ang, junk_mod, junk_ang;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      it_cnt   <= 1000;
      mdl_mod  <= '0;
      mdl_ang  <= '0;
      junk_mod <= '0;
      junk_ang <= '0;
    end else begin
      junk_mod <= $urandom;
      junk_ang <= $urandom;
      if (cordic_start) begin
        it_cnt  <= 0;
        mdl_mod <= ref_mod(cordic_x, cordic_y);
        mdl_ang <= ref_ang(cordic_x, cordic_y);
      end else if (cordic_enable) begin
        it_cnt <= it_cnt + 1;
      end
    end
  end
  assign cordic_mod   = (it_cnt == NITER - 1) ? mdl_mod : junk_mod;
  assign cordic_angle = (it_cnt == NITER - 1) ? mdl_ang : junk_ang;

  // ---------------- drivers ----------------
  initial begin : drv0
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
    forever begin
      @(negedge clock);
      if (reset && job_q0.size() != 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
        bus.req0_valid = 1'b1;
        {bus.req0_x, bus.req0_y} = job_q0[0];
      end else begin
        bus.req0_valid = 1'b0;
        bus.req0_x = $urandom;
        bus.req0_y = $urandom;
      end
    end
  end

  initial begin : drv1
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
    forever begin
      @(negedge clock);
      if (reset && job_q1.size() != 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
        bus.req1_valid = 1'b1;
        {bus.req1_x, bus.req1_y} = job_q1[0];
      end else begin
        bus.req1_valid = 1'b0;
        bus.req1_x = $urandom;
        bus.req1_y = $urandom;
      end
    end
  end

  initial begin : consumer
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (cons_hold)      bus.res_ready = 1'b0;
      else if (cons_rand) bus.res_ready = ($urandom_range(0, 3) != 0);
      else                bus.res_ready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int cyc = 0, acc_cyc = 0, exp_lat = 0, exp_en = 0, exp_st = 0, st_cnt = 0;
    logic exp_last = 1'b1, prev_rv = 1'b0, idle_next = 1'b0;
    logic [31:0] cur_x = '0, cur_y = '0;
    logic [31:0] h_mod = '0, h_ang = '0;
    logic h_id = 1'b0, h_err = 1'b0;
    forever begin
      @(negedge clock);
      #3;
      cyc++;
      if (!reset) begin
        exp_last = 1'b1; prev_rv = 1'b0; idle_next = 1'b0;
        st_cnt = 0; en_cnt = 0; in_job = 1'b0;
      end else begin
        logic v0, v1, r0, r1, rv, a0, a1, id, bad;
        logic [63:0] job;
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        r0 = bus.req0_ready; r1 = bus.req1_ready;
        rv = bus.res_valid;
        a0 = v0 && r0; a1 = v1 && r1;

        if (idle_next) begin
          check("idle_after_take", {30'd0, rv, busy}, 32'd0);
          idle_next = 1'b0;
        end
        if (r0 || r1) begin
          check("one_ready", {31'd0, r0 && r1}, 32'd0);
          check("ready_only_idle", {31'd0, busy}, 32'd0);
        end
        if (a0 || a1) begin
          id = a1;
          check("grant", {31'd0, id}, {31'd0, (v0 && v1) ? !exp_last : v1});
          exp_last = id;
          grant_log.push_back(id);
          job = '0;
          if (id ? (job_q1.size() == 0) : (job_q0.size() == 0)) begin
            errors++;
            $display("FAIL accept_nojob: requester %0d accepted with no job queued", id);
          end else begin
            job = id ? job_q1.pop_front() : job_q0.pop_front();
          end
          cur_x = job[63:32];
          cur_y = job[31:0];
          bad = ref_bad(cur_x);
          exp_q.push_back({id, bad, bad ? 32'd0 : ref_mod(cur_x, cur_y), bad ? 32'd0 : ref_ang(cur_x, cur_y)});
          acc_cyc = cyc;
          exp_lat = bad ? 1 : NITER + 2;
          exp_en  = bad ? 0 : NITER + 1;
          exp_st  = bad ? 0 : 1;
          st_cnt = 0; en_cnt = 0; in_job = 1'b1;
        end
        if (cordic_start) begin
          st_cnt++;
          check("cordic_x", cordic_x, cur_x);
          check("cordic_y", cordic_y, cur_y);
        end
        if (cordic_enable) en_cnt++;

        if (rv && !prev_rv) begin
          check("latency_cycles", 32'(cyc - acc_cyc), 32'(exp_lat));
          check("start_cycles", 32'(st_cnt), 32'(exp_st));
          check("enable_cycles", 32'(en_cnt), 32'(exp_en));
          in_job = 1'b0;
          h_id = bus.res_id; h_err = bus.res_err; h_mod = bus.res_mod; h_ang = bus.res_angle;
        end else if (rv) begin
          check("hold_id", {31'd0, bus.res_id}, {31'd0, h_id});
          check("hold_err", {31'd0, bus.res_err}, {31'd0, h_err});
          check("hold_mod", bus.res_mod, h_mod);
          check("hold_angle", bus.res_angle, h_ang);
        end
        if (rv) check("busy_in_done", {31'd0, busy}, 32'd1);

        if (rv && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: id %0d mod %h with empty queue", bus.res_id, bus.res_mod);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("res_id", {31'd0, bus.res_id}, {31'd0, e[65]});
            check("res_err", {31'd0, bus.res_err}, {31'd0, e[64]});
            check("res_mod", bus.res_mod, e[63:32]);
            check("res_angle", bus.res_angle, e[31:0]);
          end
          last_id = bus.res_id; last_err = bus.res_err;
          last_mod = bus.res_mod; last_ang = bus.res_angle;
          idle_next = 1'b1;
        end
        prev_rv = rv;
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_start"}, {31'd0, cordic_start}, 32'd0);
    check({tag, "_enable"}, {31'd0, cordic_enable}, 32'd0);
    check({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, "_res_id"}, {31'd0, bus.res_id}, 32'd0);
    check({tag, "_res_err"}, {31'd0, bus.res_err}, 32'd0);
    check({tag, "_res_mod"}, bus.res_mod, 32'd0);
    check({tag, "_res_angle"}, bus.res_angle, 32'd0);
    check({tag, "_ready0"}, {31'd0, bus.req0_ready}, 32'd0);
    check({tag, "_ready1"}, {31'd0, bus.req1_ready}, 32'd0);
    check({tag, "_cordic_x"}, cordic_x, 32'd0);
    check({tag, "_cordic_y"}, cordic_y, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((job_q0.size() != 0 || job_q1.size() != 0 || exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clock);
      #4;
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_%s: timeout, jobs %0d/%0d pending results %0d", name, job_q0.size(), job_q1.size(), exp_q.size());
    end
  endtask

  task automatic release_reset();
    @(posedge clock); #2;
    reset = 1'b1;
  endtask

  initial begin : main
    logic [31:0] x, y;
    #2 reset = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (3) @(posedge clock);
    #2 check_all_zero("reset_held");
    release_reset();

    // Fairness: both requesters loaded together, first tie goes to req0.
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      job_q0.push_back({$urandom_range(0, 32'h0100_0000), $urandom});
      job_q1.push_back({$urandom_range(0, 32'h0100_0000), $urandom});
    end
    wait_drain("fairness");
    check("fair_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("fair_grant", {31'd0, grant_log[i]}, 32'(i % 2));

    // Single job 3.0, 4.0
    @(posedge clock); #2;
    job_q0.push_back({32'h0003_0000, 32'h0004_0000});
    wait_drain("single");
    checks++;
    if (last_mod < 32'h0004_FFF0 || last_mod > 32'h0005_0010) begin
      errors++;
      $display("FAIL mod_3_4: got %h expected 00050000 within 10", last_mod);
    end

    // Range reject on requester 1
    @(posedge clock); #2;
    job_q1.push_back({32'hFFFF_0000, 32'h0002_0000});
    wait_drain("reject");
    check("reject_err", {31'd0, last_err}, 32'd1);
    check("reject_id", {31'd0, last_id}, 32'd1);

    // Boundaries around XMAX
    @(posedge clock); #2;
    job_q0.push_back({XMAX, 32'h8000_0000});
    wait_drain("xmax");
    check("xmax_err", {31'd0, last_err}, 32'd0);
    @(posedge clock); #2;
    x = XMAX + 32'd1;
    job_q0.push_back({x, 32'h0000_1000});
    wait_drain("xmax1");
    check("xmax1_err", {31'd0, last_err}, 32'd1);

    // Backpressure: result held 20 cycles while another requester waits
    @(posedge clock); #2;
    cons_hold = 1'b1;
    job_q0.push_back({32'h0001_8000, 32'hFFFE_0000});
    for (int n = 0; n < 200 && !bus.res_valid; n++) begin
      @(posedge clock); #2;
    end
    check("bp_reached_done", {31'd0, bus.res_valid}, 32'd1);
    job_q1.push_back({32'h0010_0000, 32'h0000_8000});
    repeat (20) @(posedge clock);
    #2 cons_hold = 1'b0;
    wait_drain("backpressure");

    // Random traffic with gaps and a stalling consumer
    @(posedge clock); #2;
    gaps = 1'b1;
    cons_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: x = $urandom_range(0, XMAX);
        7:                   x = XMAX + 32'($urandom_range(0, 1));
        default:             x = $urandom;
      endcase
      y = $urandom;
      if ($urandom_range(0, 1) == 0) job_q0.push_back({x, y});
      else                           job_q1.push_back({x, y});
    end
    wait_drain("random");
    gaps = 1'b0;
    cons_rand = 1'b0;

    // Reset in the middle of the iterations, then a fresh job
    @(posedge clock); #2;
    job_q0.push_back({32'h0002_0000, 32'h0001_0000});
    for (int n = 0; n < 200 && !(in_job && en_cnt >= 10); n++) begin
      @(posedge clock); #2;
    end
    check("mid_iter_reached", {31'd0, cordic_enable}, 32'd1);
    reset = 1'b0;
    #1 check_all_zero("reset_mid_iter");
    exp_q.delete();
    job_q0.delete();
    job_q1.delete();
    repeat (3) @(posedge clock);
    release_reset();
    job_q0.push_back({32'h0003_0000, 32'h0004_0000});
    wait_drain("after_reset");
    check("after_reset_id", {31'd0, last_id}, 32'd0);
    check("after_reset_err", {31'd0, last_err}, 32'd0);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
